// File: rtl/dmem_arb_pkg.sv
// Shared types, default sizes and the round-robin pick function
// used by the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_NUM_PU   = 2;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_LOCK = 4;
  localparam int MAX_PU       = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // One-hot winner: first set bit of req scanning ptr, ptr+1, ... mod n.
  function automatic logic [MAX_PU-1:0] rr_pick(input logic [MAX_PU-1:0] req,
                                                 input logic [2:0]        ptr,
                                                 input int                n);
    logic [MAX_PU-1:0] win;
    logic [2:0]        idx;
    win = '0;
    for (int k = 0; k < MAX_PU; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if ((k < n) && (win == '0) && req[idx]) win[idx] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate from ptr and priority-encode
// the request vector into a one-hot grant.
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [MAX_PU-1:0] pick;
  logic              unused_pick;

  assign pick        = rr_pick(MAX_PU'(req), 3'(ptr), N);
  assign gnt         = pick[N-1:0];
  // Bits above N are always zero; fold them so the whole vector is consumed.
  assign unused_pick = ^pick;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous-read data memory
// between NUM_PU units, with a bounded lock for atomic read-modify-write.
//
// state  | meaning
// ARB    | round-robin among all requesters starting at ptr
// LOCKED | only owner may be granted; lock_cnt counts its consecutive grants
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_PU   = DEF_NUM_PU,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PU-1:0]        req,
  input  logic [NUM_PU-1:0]        we,
  input  logic [NUM_PU-1:0]        lock,
  input  logic [NUM_PU*ADDR_W-1:0] addr,
  input  logic [NUM_PU*DATA_W-1:0] wdata,
  output logic [NUM_PU-1:0]        gnt,
  output logic [NUM_PU-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PTR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_PU-1:0] rd_id_q, rd_id_d;

  logic [NUM_PU-1:0] pick;
  logic [NUM_PU-1:0] gnt_int;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  win_nxt;
  logic              locked_hold;

  // ptr already points past the owner while locked, so a dropped-req
  // release arbitrates from owner+1 without extra muxing.
  rr_picker #(
    .N     (NUM_PU),
    .PTR_W (PTR_W)
  ) u_picker (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  assign locked_hold = (state_q == LOCKED) && req[owner_q];

  always_comb begin
    gnt_int = '0;
    if (rst)              gnt_int = '0;
    else if (locked_hold) gnt_int = NUM_PU'(1) << owner_q;
    else                  gnt_int = pick;
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (gnt_int[i]) win_idx = PTR_W'(i);
    end
    win_nxt = (win_idx == PTR_W'(NUM_PU - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (gnt_int[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_en = |gnt_int;
  assign gnt    = gnt_int;
  assign rvalid = rd_id_q;
  assign rdata  = mem_rdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rd_id_d = (mem_en && !mem_we) ? gnt_int : '0;

    if (locked_hold) begin
      if (!lock[owner_q] || ((cnt_q + 1'b1) >= CNT_W'(MAX_LOCK))) begin
        state_d = ARB;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = ARB;
      cnt_d   = '0;
      if (mem_en) begin
        ptr_d = win_nxt;
        // With MAX_LOCK==1 the first grant already exhausts the lock.
        if (lock[win_idx] && (MAX_LOCK > 1)) begin
          state_d = LOCKED;
          owner_d = win_idx;
          cnt_d   = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rd_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rd_id_q <= rd_id_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with two PUs and a behavioural
// synchronous-read memory attached to the mem_* port.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  lock;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic [1:0]  exp5 [8];
  int          n_chk;
  int          n_pass;

  dmem_arbiter #(
    .NUM_PU   (2),
    .ADDR_W   (8),
    .DATA_W   (32),
    .MAX_LOCK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req   = r;
    we    = w;
    lock  = l;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'h11;
    mem[8'h60] = 32'h22;
    mem[8'h21] = 32'h33;
    mem_rdata  = '0;
    exp5 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};

    // Reset held with a request pending: nothing may be granted.
    rst = 1'b1;
    drive(2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 0, 0);
    @(negedge clk); #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_mem_en", 32'(mem_en), 32'h0);
      chk("idle_rvalid", 32'(rvalid), 32'h0);
    end

    // Reset arrives while a read is in flight.
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 0, 0);
    #1;
    chk("midrd_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("midrd_rv_in_rst", 32'(rvalid), 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrd_rv_after", 32'(rvalid), 32'h0);

    // Two continuous readers alternate.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) drive(2'b11, 2'b00, 2'b00, 8'h20, 8'h60, 0, 0);
      #1;
      chk("rr_gnt", 32'(gnt), (k % 2 == 1) ? 32'h2 : 32'h1);
      chk("rr_addr", 32'(mem_addr), (k % 2 == 1) ? 32'h60 : 32'h20);
      if (k > 0) begin
        chk("rr_rvalid", 32'(rvalid), (k % 2 == 1) ? 32'h1 : 32'h2);
        chk("rr_rdata", rdata, (k % 2 == 1) ? 32'h11 : 32'h22);
      end
    end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1;
    chk("rr_last_rvalid", 32'(rvalid), 32'h2);
    chk("rr_last_rdata", rdata, 32'h22);
    chk("rr_idle_gnt", 32'(gnt), 32'h0);

    // Write then read of the same word by the other PU.
    @(negedge clk);
    drive(2'b11, 2'b01, 2'b00, 8'h20, 8'h20, 32'hDEAD, 0);
    #1;
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_wdata", mem_wdata, 32'hDEAD);
    @(negedge clk);
    drive(2'b10, 2'b00, 2'b00, 8'h20, 8'h20, 0, 0);
    #1;
    chk("wr_rd_gnt", 32'(gnt), 32'h2);
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1;
    chk("wr_rd_rvalid", 32'(rvalid), 32'h2);
    chk("wr_rd_rdata", rdata, 32'hDEAD);

    // PU0 write moves ptr to 1, then PU1 performs a locked sequence.
    @(negedge clk);
    drive(2'b01, 2'b01, 2'b00, 8'h30, 8'h00, 32'h5, 0);
    #1;
    chk("lk_pre_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b10, 8'h40, 8'h21, 0, 0);
    #1;
    chk("lk_rd_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    drive(2'b11, 2'b10, 2'b10, 8'h40, 8'h21, 0, 32'hBEEF);
    #1;
    chk("lk_wr_gnt", 32'(gnt), 32'h2);
    chk("lk_rd_rvalid", 32'(rvalid), 32'h2);
    chk("lk_rd_rdata", rdata, 32'h33);
    @(negedge clk);
    drive(2'b11, 2'b10, 2'b00, 8'h40, 8'h22, 0, 32'h77);
    #1;
    chk("lk_last_gnt", 32'(gnt), 32'h2);
    chk("lk_wr_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, 8'h40, 8'h22, 0, 0);
    #1;
    chk("lk_release_gnt", 32'(gnt), 32'h1);
    chk("lk_mem21", mem[8'h21], 32'hBEEF);
    chk("lk_mem22", mem[8'h22], 32'h77);
    @(negedge clk); #1;
    chk("lk_after_gnt", 32'(gnt), 32'h2);
    chk("lk_after_rvalid", 32'(rvalid), 32'h1);
    chk("lk_after_rdata", rdata, 32'h0);

    // Lock timeout: PU0 may hold at most four consecutive grants.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) drive(2'b11, 2'b00, 2'b01, 8'h20, 8'h60, 0, 0);
      #1;
      chk($sformatf("to_gnt%0d", k), 32'(gnt), 32'(exp5[k]));
    end

    // Owner drops req while locked: PU1 wins in the same cycle.
    @(negedge clk);
    drive(2'b10, 2'b00, 2'b01, 8'h20, 8'h60, 0, 0);
    #1;
    chk("drop_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 8'h20, 8'h60, 0, 0);
    #1;
    chk("drop_next_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, 8'h20, 8'h60, 0, 0);
    #1;
    chk("drop_arb_gnt", 32'(gnt), 32'h2);

    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    #1;
    chk("end_gnt", 32'(gnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
